// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with a valid/ready load port.
// Define PISO_TX_PARITY_EN to append an even-parity bit after each data word.
module piso_tx #(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic [W-1:0] din,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic         shift_en,
    output logic         sout,
    output logic         sout_valid,
    output logic         frame_start,
    output logic         busy
);
    localparam int CW = $clog2(W);
    localparam int FB = MSB_FIRST ? W - 1 : 0;

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t        state, state_n;
    logic [W-1:0]  sreg, sreg_n, sreg_rot;
    logic [CW-1:0] cnt, cnt_n;
    logic          sout_n, sout_valid_n, frame_start_n;
    logic          last;

    assign last = (cnt == CW'(W - 1));
    assign busy = (state != IDLE);

    // Rotating keeps the next bit at the output position without a mux tree.
    always_comb begin
        if (MSB_FIRST)
            sreg_rot = {sreg[W-2:0], sreg[W-1]};
        else
            sreg_rot = {sreg[0], sreg[W-1:1]};
    end

`ifdef PISO_TX_PARITY_EN
    logic par;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            par <= 1'b0;
        else if (state == IDLE && load_valid)
            par <= ^din;
    end
`endif

    always_comb begin
        state_n       = state;
        sreg_n        = sreg;
        cnt_n         = cnt;
        sout_n        = sout;
        sout_valid_n  = sout_valid;
        frame_start_n = frame_start;
        load_ready    = 1'b0;
        unique case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    state_n       = SHIFT;
                    sreg_n        = din;
                    cnt_n         = '0;
                    sout_n        = din[FB];
                    sout_valid_n  = 1'b1;
                    frame_start_n = 1'b1;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    frame_start_n = 1'b0;
                    if (last) begin
`ifdef PISO_TX_PARITY_EN
                        state_n      = PARITY;
                        sout_n       = par;
                        sout_valid_n = 1'b1;
`else
                        state_n      = IDLE;
                        sout_n       = 1'b0;
                        sout_valid_n = 1'b0;
`endif
                    end else begin
                        cnt_n  = cnt + CW'(1);
                        sreg_n = sreg_rot;
                        sout_n = sreg_rot[FB];
                    end
                end
            end
`ifdef PISO_TX_PARITY_EN
            PARITY: begin
                if (shift_en) begin
                    state_n      = IDLE;
                    sout_n       = 1'b0;
                    sout_valid_n = 1'b0;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= IDLE;
            sreg        <= '0;
            cnt         <= '0;
            sout        <= 1'b0;
            sout_valid  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            sreg        <= sreg_n;
            cnt         <= cnt_n;
            sout        <= sout_n;
            sout_valid  <= sout_valid_n;
            frame_start <= frame_start_n;
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed bench for piso_tx, LSB-first and MSB-first instances.
// Frame length tracks PISO_TX_PARITY_EN.
module tb_piso_tx;
    localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic clk = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] din_a = '0, din_b = '0;
    logic lv_a = 1'b0, se_a = 1'b0, lv_b = 1'b0, se_b = 1'b0;
    logic lr_a, sout_a, sv_a, fs_a, busy_a;
    logic lr_b, sout_b, sv_b, fs_b, busy_b;

    piso_tx #(.W(W), .MSB_FIRST(1'b0)) u_a (
        .clk(clk), .clrn(clrn), .din(din_a), .load_valid(lv_a),
        .load_ready(lr_a), .shift_en(se_a), .sout(sout_a),
        .sout_valid(sv_a), .frame_start(fs_a), .busy(busy_a)
    );

    piso_tx #(.W(W), .MSB_FIRST(1'b1)) u_b (
        .clk(clk), .clrn(clrn), .din(din_b), .load_valid(lv_b),
        .load_ready(lr_b), .shift_en(se_b), .sout(sout_b),
        .sout_valid(sv_b), .frame_start(fs_b), .busy(busy_b)
    );

    int tests = 0;
    int fails = 0;

    logic s[64], v[64], f[64];
    int ncap;
    int mid_k = -1;
    logic [W-1:0] mid_w = '0;
    logic [W-1:0] wq[$];
    int nfr, gap, fs_cnt, fs_bad;
    logic [15:0] fw[4];
    int flen[4];

    // Records instance A outputs per cycle; refills din from wq on each accept.
    task automatic cap_a(input int n);
        logic acc;
        ncap = n;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            s[k] = sout_a; v[k] = sv_a; f[k] = fs_a;
            acc = lr_a && lv_a;
            if (k == mid_k) begin
                lv_a = 1'b1;
                din_a = mid_w;
            end
            @(posedge clk); #1;
            if (acc) begin
                if (wq.size() > 0) din_a = wq.pop_front();
                else lv_a = 1'b0;
            end
        end
    endtask

    task automatic frames_a();
        bit inf = 0;
        int end_k = -1;
        nfr = 0; gap = -1; fs_cnt = 0; fs_bad = 0;
        for (int i = 0; i < 4; i++) begin
            fw[i] = '0;
            flen[i] = 0;
        end
        for (int k = 0; k < ncap; k++) begin
            if (f[k]) begin
                fs_cnt++;
                if (!(v[k] && (k == 0 || !v[k-1]))) fs_bad++;
            end
            if (v[k]) begin
                if (!inf) begin
                    inf = 1;
                    if (nfr == 1) gap = k - end_k;
                end
                if (nfr < 4 && flen[nfr] < 16) begin
                    fw[nfr][flen[nfr]] = s[k];
                    flen[nfr]++;
                end
            end else if (inf) begin
                inf = 0;
                end_k = k;
                nfr++;
            end
        end
        if (inf) nfr++;
    endtask

    task automatic test_reset();
        tests++;
        if ({sout_a, sv_a, fs_a, busy_a, lr_a} !== 5'b00001) begin
            fails++;
            $display("FAIL rst_init: got %b want 00001", {sout_a, sv_a, fs_a, busy_a, lr_a});
        end
        @(negedge clk); clrn = 1'b1;
        @(posedge clk); #1;
        din_a = 8'h3C; lv_a = 1'b1; se_a = 1'b1;
        @(posedge clk); #1;
        lv_a = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if ({sout_a, sv_a, busy_a} !== 3'b111) begin
            fails++;
            $display("FAIL rst_prebit: got %b want 111", {sout_a, sv_a, busy_a});
        end
        #2 clrn = 1'b0;
        #1;
        tests++;
        if ({sout_a, sv_a, fs_a, busy_a, lr_a} !== 5'b00001) begin
            fails++;
            $display("FAIL rst_async: got %b want 00001", {sout_a, sv_a, fs_a, busy_a, lr_a});
        end
        @(posedge clk); @(negedge clk);
        tests++;
        if (sv_a !== 1'b0) begin
            fails++;
            $display("FAIL rst_hold: sv got %b want 0", sv_a);
        end
        clrn = 1'b1;
        #1;
        tests++;
        if (lr_a !== 1'b1) begin
            fails++;
            $display("FAIL rst_release_ready: got %b want 1", lr_a);
        end
        @(posedge clk); #1;
        tests++;
        if ({sv_a, busy_a} !== 2'b00) begin
            fails++;
            $display("FAIL rst_no_bits: got %b want 00", {sv_a, busy_a});
        end
    endtask

    task automatic test_lsb();
        din_a = 8'hA5; lv_a = 1'b1; se_a = 1'b1;
        cap_a(FL + 6);
        frames_a();
        tests++;
        if (nfr !== 1 || fw[0][7:0] !== 8'hA5) begin
            fails++;
            $display("FAIL lsb_bits: got %0d frames %h want 1 frame a5", nfr, fw[0][7:0]);
        end
        tests++;
        if (flen[0] !== FL) begin
            fails++;
            $display("FAIL lsb_len: got %0d want %0d", flen[0], FL);
        end
        tests++;
        if (fs_cnt !== 1 || fs_bad !== 0) begin
            fails++;
            $display("FAIL lsb_fstart: got cnt %0d bad %0d want 1 0", fs_cnt, fs_bad);
        end
`ifdef PISO_TX_PARITY_EN
        tests++;
        if (fw[0][8] !== 1'b0) begin
            fails++;
            $display("FAIL lsb_parity: got %b want 0", fw[0][8]);
        end
`endif
    endtask

    task automatic test_msb();
        logic [15:0] got = '0;
        int vc = 0, hold_bad = 0, busy_bad = 0, fsc = 0;
        din_b = 8'h81; lv_b = 1'b1; se_b = 1'b0;
        @(posedge clk); #1;
        lv_b = 1'b0;
        for (int k = 0; k < 4 * FL + 6; k++) begin
            @(negedge clk);
            if (sv_b) begin
                vc++;
                if (k % 4 == 0) got[k/4] = sout_b;
                else if (sout_b !== got[k/4]) hold_bad++;
                if (!busy_b) busy_bad++;
                if (fs_b) fsc++;
            end
            se_b = (k % 4 == 3);
        end
        se_b = 1'b0;
        tests++;
        if (got[7:0] !== 8'h81) begin
            fails++;
            $display("FAIL msb_bits: got %h want 81", got[7:0]);
        end
        tests++;
        if (vc !== 4 * FL || hold_bad !== 0) begin
            fails++;
            $display("FAIL msb_hold: got %0d valid %0d bad want %0d 0", vc, hold_bad, 4 * FL);
        end
        tests++;
        if (busy_bad !== 0 || busy_b !== 1'b0) begin
            fails++;
            $display("FAIL msb_busy: got %0d gaps end %b want 0 0", busy_bad, busy_b);
        end
        tests++;
        if (fsc !== 4) begin
            fails++;
            $display("FAIL msb_fstart_hold: got %0d want 4", fsc);
        end
`ifdef PISO_TX_PARITY_EN
        tests++;
        if (got[8] !== 1'b0) begin
            fails++;
            $display("FAIL msb_parity: got %b want 0", got[8]);
        end
`endif
    endtask

    task automatic test_msb_order();
        logic [15:0] got = '0;
        int n = 0;
        @(posedge clk); #1;
        din_b = 8'h35; lv_b = 1'b1; se_b = 1'b1;
        @(posedge clk); #1;
        lv_b = 1'b0;
        for (int k = 0; k < FL + 4; k++) begin
            @(negedge clk);
            if (sv_b && n < 16) begin
                got[n] = sout_b;
                n++;
            end
        end
        se_b = 1'b0;
        tests++;
        if (got[7:0] !== 8'hAC || n !== FL) begin
            fails++;
            $display("FAIL msb_order: got %h len %0d want ac len %0d", got[7:0], n, FL);
        end
    endtask

    task automatic test_load_busy();
        din_a = 8'h12; lv_a = 1'b1; se_a = 1'b1;
        mid_k = 3; mid_w = 8'hFF;
        cap_a(2 * FL + 8);
        mid_k = -1;
        frames_a();
        tests++;
        if (nfr !== 2 || fw[0][7:0] !== 8'h12) begin
            fails++;
            $display("FAIL busy_first: got %0d frames %h want 2 frames 12", nfr, fw[0][7:0]);
        end
        tests++;
        if (fw[1][7:0] !== 8'hFF || gap !== 1) begin
            fails++;
            $display("FAIL busy_second: got %h gap %0d want ff gap 1", fw[1][7:0], gap);
        end
    endtask

    task automatic test_back_to_back();
        din_a = 8'h0F; lv_a = 1'b1; se_a = 1'b1;
        wq.push_back(8'hF0);
        cap_a(2 * FL + 8);
        frames_a();
        tests++;
        if (nfr !== 2 || fw[0][7:0] !== 8'h0F || fw[1][7:0] !== 8'hF0) begin
            fails++;
            $display("FAIL b2b_words: got %0d frames %h %h want 2 0f f0", nfr, fw[0][7:0], fw[1][7:0]);
        end
        tests++;
        if (gap !== 1) begin
            fails++;
            $display("FAIL b2b_gap: got %0d want 1", gap);
        end
        tests++;
        if (flen[0] !== FL || flen[1] !== FL || fs_cnt !== 2 || fs_bad !== 0) begin
            fails++;
            $display("FAIL b2b_len: got %0d %0d fs %0d/%0d want %0d %0d fs 2/0",
                     flen[0], flen[1], fs_cnt, fs_bad, FL, FL);
        end
    endtask

`ifdef PISO_TX_PARITY_EN
    task automatic test_parity();
        din_a = 8'h07; lv_a = 1'b1; se_a = 1'b1;
        wq.push_back(8'h03);
        cap_a(2 * FL + 8);
        frames_a();
        tests++;
        if (nfr !== 2 || fw[0][8:0] !== 9'h107) begin
            fails++;
            $display("FAIL par_07: got %0d frames %h want 2 107", nfr, fw[0][8:0]);
        end
        tests++;
        if (fw[1][8:0] !== 9'h003) begin
            fails++;
            $display("FAIL par_03: got %h want 003", fw[1][8:0]);
        end
        tests++;
        if (flen[0] !== 9 || flen[1] !== 9) begin
            fails++;
            $display("FAIL par_len: got %0d %0d want 9 9", flen[0], flen[1]);
        end
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_lsb();
        test_msb();
        test_msb_order();
        test_load_busy();
        test_back_to_back();
`ifdef PISO_TX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
